// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up/down counter (00-99) with clock-divider prescaler,
// start/stop toggle and parallel load. Digits are always valid BCD.
//
// Parameters:
//   DIV         clock cycles per count step (DIV >= 1)
// Ports:
//   clk         clock, all logic on rising edge
//   rst         synchronous active-high reset
//   start_stop  level input; each rising edge toggles run/stop
//   dir         1 = count up, 0 = count down (sampled on every step)
//   load        load digits from load_tens/load_units (values > 9 load 0)
//   load_tens   tens value for load
//   load_units  units value for load
//   tens        registered BCD tens digit
//   units       registered BCD units digit
//   running     high while in the running state
//   wrap        one-cycle pulse aligned with the digits after a 99<->00 step
module bcd_counter_2d #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PLast = PW'(DIV - 1);

  typedef enum logic [0:0] {StStopped, StRunning} state_e;

  state_e        state_q, state_d;
  logic          ss_q;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic          wrap_q, wrap_d;

  logic ss_edge;
  logic pcnt_last;
  logic step;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > 4'd9) ? 4'd0 : v;
  endfunction

  always_comb begin
    ss_edge   = start_stop & ~ss_q;
    pcnt_last = (pcnt_q == PLast);
    // A toggle edge suppresses the step on the same edge; load discards it.
    step      = (state_q == StRunning) && pcnt_last && !ss_edge && !load;

    state_d = state_q;
    if (ss_edge) begin
      state_d = (state_q == StRunning) ? StStopped : StRunning;
    end

    // Prescaler only advances while running, so a pause keeps the phase.
    pcnt_d = pcnt_q;
    if (load) begin
      pcnt_d = '0;
    end else if (state_q == StRunning) begin
      pcnt_d = pcnt_last ? '0 : pcnt_q + PW'(1);
    end

    tens_d  = tens_q;
    units_d = units_q;
    wrap_d  = 1'b0;
    if (load) begin
      tens_d  = clamp_bcd(load_tens);
      units_d = clamp_bcd(load_units);
    end else if (step) begin
      if (dir) begin
        if (units_q == 4'd9) begin
          units_d = 4'd0;
          if (tens_q == 4'd9) begin
            tens_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          units_d = units_q + 4'd1;
        end
      end else begin
        if (units_q == 4'd0) begin
          units_d = 4'd9;
          if (tens_q == 4'd0) begin
            tens_d = 4'd9;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q - 4'd1;
          end
        end else begin
          units_d = units_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StStopped;
      // Capture the live input so a level held through reset is not an edge.
      ss_q    <= start_stop;
      pcnt_q  <= '0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= start_stop;
      pcnt_q  <= pcnt_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      wrap_q  <= wrap_d;
    end
  end

  assign tens    = tens_q;
  assign units   = units_q;
  assign running = (state_q == StRunning);
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_counter_2d.sv
module tb_bcd_counter_2d;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop;
  logic       dir;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_units;

  logic [3:0] tens4, units4, tens1, units1;
  logic       running4, wrap4, running1, wrap1;

  always #5 clk = ~clk;

  bcd_counter_2d #(.DIV(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .dir        (dir),
    .load       (load),
    .load_tens  (load_tens),
    .load_units (load_units),
    .tens       (tens4),
    .units      (units4),
    .running    (running4),
    .wrap       (wrap4)
  );

  bcd_counter_2d #(.DIV(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .dir        (dir),
    .load       (load),
    .load_tens  (load_tens),
    .load_units (load_units),
    .tens       (tens1),
    .units      (units1),
    .running    (running1),
    .wrap       (wrap1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: count held as an integer 0..99, phase as a cycle count.
  int m_div[2] = '{4, 1};
  int m_val[2];
  int m_ph[2];
  bit m_run[2];
  bit m_wrap[2];
  bit m_ssp[2];

  function automatic int clampv(input logic [3:0] v);
    return (v > 9) ? 0 : int'(v);
  endfunction

  task automatic model_edge(input int i);
    bit edge_seen;
    bit fire;
    if (rst) begin
      m_val[i] = 0; m_ph[i] = 0; m_run[i] = 0; m_wrap[i] = 0; m_ssp[i] = start_stop;
      return;
    end
    edge_seen = start_stop && !m_ssp[i];
    m_ssp[i]  = start_stop;
    fire      = m_run[i] && (m_ph[i] == m_div[i] - 1);
    m_wrap[i] = 0;
    if (load) begin
      m_val[i] = clampv(load_tens) * 10 + clampv(load_units);
    end else if (fire && !edge_seen) begin
      if (dir) begin
        m_wrap[i] = (m_val[i] == 99);
        m_val[i]  = (m_val[i] + 1) % 100;
      end else begin
        m_wrap[i] = (m_val[i] == 0);
        m_val[i]  = (m_val[i] + 99) % 100;
      end
    end
    if (load) m_ph[i] = 0;
    else if (m_run[i]) m_ph[i] = (m_ph[i] + 1) % m_div[i];
    if (edge_seen) m_run[i] = !m_run[i];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check("d4_val",  int'(tens4) * 10 + int'(units4), m_val[0]);
    check("d4_run",  int'(running4), int'(m_run[0]));
    check("d4_wrap", int'(wrap4), int'(m_wrap[0]));
    check("d4_bcd",  int'(tens4 <= 9 && units4 <= 9), 1);
    check("d1_val",  int'(tens1) * 10 + int'(units1), m_val[1]);
    check("d1_run",  int'(running1), int'(m_run[1]));
    check("d1_wrap", int'(wrap1), int'(m_wrap[1]));
    check("d1_bcd",  int'(tens1 <= 9 && units1 <= 9), 1);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input logic [3:0] lt, input logic [3:0] lu);
    load = 1'b1; load_tens = lt; load_units = lu;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    tick();
    start_stop = 1'b0;
  endtask

  initial begin
    int held;
    rst = 1'b1; start_stop = 1'b1; dir = 1'b1; load = 1'b0;
    load_tens = 4'd0; load_units = 4'd0;
    #1;

    // Reset with start_stop held high: no toggle afterwards.
    ticks(3);
    rst = 1'b0;
    ticks(3);
    check("hold_ss_run", int'(running4), 0);
    check("hold_ss_val", int'(tens4) * 10 + int'(units4), 0);

    // DIV=4 start latency and period.
    start_stop = 1'b0;
    tick();
    pulse_ss();
    check("start_run", int'(running4), 1);
    ticks(3);
    check("u_before4", int'(units4), 0);
    tick();
    check("u_at4", int'(units4), 1);
    ticks(4);
    check("u_at8", int'(units4), 2);
    ticks(8);

    // DIV=1 up wrap.
    dir = 1'b1;
    do_load(4'd9, 4'd8);
    tick();
    check("up_99", int'(tens1) * 10 + int'(units1), 99);
    tick();
    check("up_00", int'(tens1) * 10 + int'(units1), 0);
    check("up_wrap", int'(wrap1), 1);
    tick();
    check("up_01", int'(units1), 1);
    check("up_wrap_off", int'(wrap1), 0);

    // DIV=1 down wrap and tens borrow.
    dir = 1'b0;
    do_load(4'd0, 4'd1);
    ticks(2);
    check("dn_99", int'(tens1) * 10 + int'(units1), 99);
    check("dn_wrap", int'(wrap1), 1);
    tick();
    check("dn_98", int'(tens1) * 10 + int'(units1), 98);
    do_load(4'd1, 4'd0);
    tick();
    check("dn_borrow", int'(tens1) * 10 + int'(units1), 9);

    // Phase hold on DIV=4: stop at pcnt=2, restart, step one cycle later.
    dir = 1'b1;
    do_load(4'd3, 4'd0);
    ticks(2);
    pulse_ss();
    check("stopped", int'(running4), 0);
    held = int'(tens4) * 10 + int'(units4);
    ticks(10);
    check("held_val", int'(tens4) * 10 + int'(units4), held);
    pulse_ss();
    check("restart_noop", int'(tens4) * 10 + int'(units4), held);
    tick();
    check("restart_step", int'(tens4) * 10 + int'(units4), held + 1);

    // Load while running; out-of-range tens loads 0.
    do_load(4'd12, 4'd7);
    check("ld_val", int'(tens4) * 10 + int'(units4), 7);
    check("ld_run", int'(running4), 1);
    ticks(3);
    check("ld_pcnt_clr", int'(units4), 7);
    tick();
    check("ld_then_step", int'(units4), 8);

    // Load coincident with a wrapping step edge on DIV=1.
    do_load(4'd9, 4'd9);
    do_load(4'd9, 4'd9);
    check("ld_win_val", int'(tens1) * 10 + int'(units1), 99);
    check("ld_win_wrap", int'(wrap1), 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 40) == 0) dir = ~dir;
      load       = ($urandom_range(0, 29) == 0);
      load_tens  = 4'($urandom_range(0, 15));
      load_units = 4'($urandom_range(0, 15));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_counter_2d.md
# bcd_counter_2d

Two-digit BCD up/down counter, 00–99, with a clock-divider prescaler, start/stop toggle and parallel load. Produces the `tens`/`units` digit pair consumed directly by the seven-segment display decoder stage. Outputs are always valid BCD (0–9), so the decoder never reaches its blank default.

## Interface

Parameters:
- `DIV`, default 50_000_000: clock cycles per count step. Legal range is DIV ≥ 1. Prescaler width is $clog2(DIV), minimum 1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start_stop`  in  1  level input, already synchronous to `clk`; each rising edge toggles run/stop
- `dir`  in  1  1 = count up, 0 = count down; sampled on every step
- `load`  in  1  when high at a clock edge, digits take `load_tens`/`load_units`
- `load_tens`  in  4  tens value for load
- `load_units`  in  4  units value for load
- `tens`  out  4  BCD tens digit, registered
- `units`  out  4  BCD units digit, registered
- `running`  out  1  1 while in RUNNING state
- `wrap`  out  1  one-cycle pulse on the step that crosses 99→00 (up) or 00→99 (down)

## Operation

- State machine has two states.
  - STOPPED (reset state): rising edge on `start_stop` moves to RUNNING.
  - RUNNING: rising edge on `start_stop` moves to STOPPED.
  - `running` = (state == RUNNING).
- Edge detect: register `ss_q` holds the previous `start_stop`. Edge = `start_stop & ~ss_q`. During reset `ss_q <= start_stop`, so an input held high through reset does not toggle.
- Prescaler `pcnt`:
  - RUNNING: increments each cycle. When `pcnt == DIV-1`, a step fires and `pcnt` returns to 0.
  - STOPPED: holds its value, so pause/resume keeps the phase.
  - Load clears `pcnt` to 0.
- Step, up: units 0–8 → +1. Units 9 → units 0 and tens +1. At 99 → 00, with `wrap` = 1.
- Step, down: units 1–9 → −1. Units 0 → units 9 and tens −1. At 00 → 99, with `wrap` = 1.
- Load:
  - Each digit loads its input if ≤ 9. A value of 10–15 loads 0 for that digit only.
  - The state is not changed by load.
- Priority within one cycle is rst > load > step.
  - A step coincident with load is discarded, and `wrap` stays 0 on that cycle.
  - A `start_stop` edge is applied independently of load.
- `wrap` is registered. It is high only during the cycle after the wrapping step edge, i.e. it is aligned with the new digit values.

## Timing

- Reset values: `tens`=0, `units`=0, `running`=0, `wrap`=0, `pcnt`=0, state STOPPED.
- Start latency:
  - `start_stop` first seen high at edge N → `running`=1 after edge N.
  - The first step updates the digits at edge N+DIV, when `pcnt` was 0 at N.
- Step period is exactly DIV cycles while RUNNING. With DIV=1, one step per cycle.
- Stop: an edge seen at edge M means no step at edge M or later, even if `pcnt == DIV-1` at M. Toggle takes precedence over a step.
- Load latency: digits show the loaded value after the edge where `load` = 1.
- Reset mid-count: the next edge with `rst`=1 forces all reset values. No step and no `wrap` pulse occur on that edge.
- `dir` change takes effect on the next step. There is no glitch and no extra step.

## Test plan

- Reset with `start_stop` held high, then release reset → `running` stays 0. Digits 00, `wrap` 0.
- DIV=4, up, pulse `start_stop` → `running`=1. Units goes 1 after 4 cycles, 2 after 8, and steps every 4 cycles thereafter.
- DIV=1, up, load 98, run → sequence 98, 99, 00 (`wrap`=1 for exactly that cycle), 01. `tens`/`units` never exceed 9.
- DIV=1, down, load 01, run → sequence 01, 00, 99 (`wrap`=1), 98. With load 10 → 09, i.e. tens borrow.
- DIV=4: stop when `pcnt`=2, wait 10 cycles, restart → the next step comes 1 cycle after restart (phase held). Digits unchanged while stopped.
- Load with `load_tens`=12, `load_units`=7 while RUNNING → digits 07, `pcnt` cleared, still running. Load coincident with a step edge → loaded value wins, `wrap`=0.
